// File: rtl/bomb_timer_scheduler.sv
// -----------------------------------------------------------------------------
// bomb_timer_scheduler
//
// Pool of bomb slots that share the one-second tick from the slow-clock
// generator. A placement request takes the lowest free slot, arms its fuse and
// latches the grid cell. Each armed fuse counts down on the shared tick. The
// slot then enters a blast phase for a fixed number of ticks and returns to the
// pool. A chain request detonates an armed slot immediately.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset (priority over everything)
//   one_sec       one-cycle tick from the slow-clock generator
//   place_req     single-cycle request to place a bomb at place_row/place_col
//   place_row     grid row of the requested bomb
//   place_col     grid column of the requested bomb
//   chain_det     per-slot early detonation (slot caught in another blast)
//   place_ack     one-cycle pulse, bomb accepted into slot place_slot
//   place_nack    one-cycle pulse, bomb rejected (pool full or cell occupied)
//   place_slot    slot index of the accepted bomb, valid with place_ack
//   armed         per-slot: fuse burning
//   blasting      per-slot: explosion active
//   explode_pulse per-slot one-cycle pulse on entering the blast phase
//   slot_row      packed row per slot, slot i at [i*COORD_W +: COORD_W]
//   slot_col      packed column per slot, same packing
// -----------------------------------------------------------------------------
module bomb_timer_scheduler #(
  parameter int NUM_BOMBS = 4,
  parameter int FUSE_SEC  = 3,
  parameter int BLAST_SEC = 1,
  parameter int COORD_W   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           one_sec,
  input  logic                           place_req,
  input  logic [COORD_W-1:0]             place_row,
  input  logic [COORD_W-1:0]             place_col,
  input  logic [NUM_BOMBS-1:0]           chain_det,
  output logic                           place_ack,
  output logic                           place_nack,
  output logic [$clog2(NUM_BOMBS)-1:0]   place_slot,
  output logic [NUM_BOMBS-1:0]           armed,
  output logic [NUM_BOMBS-1:0]           blasting,
  output logic [NUM_BOMBS-1:0]           explode_pulse,
  output logic [NUM_BOMBS*COORD_W-1:0]   slot_row,
  output logic [NUM_BOMBS*COORD_W-1:0]   slot_col
);

  localparam int SLOT_W  = $clog2(NUM_BOMBS);
  localparam int MAX_SEC = (FUSE_SEC > BLAST_SEC) ? FUSE_SEC : BLAST_SEC;
  localparam int CNT_W   = $clog2(MAX_SEC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_BLAST = 2'd2
  } slot_state_e;

  slot_state_e               state_q   [NUM_BOMBS];
  logic [CNT_W-1:0]          cnt_q     [NUM_BOMBS];
  logic [COORD_W-1:0]        row_q     [NUM_BOMBS];
  logic [COORD_W-1:0]        col_q     [NUM_BOMBS];
  logic [NUM_BOMBS-1:0]      explode_q;
  logic                      place_ack_q;
  logic                      place_nack_q;
  logic [SLOT_W-1:0]         place_slot_q;

  // Placement decision, made from the state as it stands this cycle. A slot
  // that is leaving BLAST right now is still BLAST here, so it is not offered
  // to a request until the following cycle.
  logic                      free_found_d;
  logic [SLOT_W-1:0]         free_idx_d;
  logic                      dup_hit_d;
  logic                      accept_d;
  logic                      reject_d;

  // NOTE: every variable written in always_comb gets a default before any
  // conditional assignment, otherwise synthesis infers a latch for the
  // paths that leave it untouched.
  always_comb begin
    free_found_d = 1'b0;
    free_idx_d   = '0;
    dup_hit_d    = 1'b0;
    // Scan from the top down so the lowest free index wins.
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (state_q[i] == S_IDLE) begin
        free_found_d = 1'b1;
        free_idx_d   = SLOT_W'(i);
      end
    end
    // Only occupied slots count: idle slots hold cleared coordinates that
    // would otherwise collide with a bomb at cell (0,0).
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (state_q[i] != S_IDLE && row_q[i] == place_row && col_q[i] == place_col) begin
        dup_hit_d = 1'b1;
      end
    end
    accept_d = place_req && free_found_d && !dup_hit_d;
    reject_d = place_req && !accept_d;
  end

  // Per-slot FSMs and registered handshake outputs.
  // NOTE: all state here uses non-blocking assignments so every slot sees the
  // same pre-edge values regardless of loop or statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-slot arrays are small flop banks, not RAM, and the
      // coordinates must read 0 out of reset, so they are reset explicitly.
      for (int i = 0; i < NUM_BOMBS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        row_q[i]   <= '0;
        col_q[i]   <= '0;
      end
      explode_q    <= '0;
      place_ack_q  <= 1'b0;
      place_nack_q <= 1'b0;
      place_slot_q <= '0;
    end else begin
      place_ack_q  <= accept_d;
      place_nack_q <= reject_d;
      place_slot_q <= accept_d ? free_idx_d : '0;

      for (int i = 0; i < NUM_BOMBS; i++) begin
        explode_q[i] <= 1'b0;
        case (state_q[i])
          S_IDLE: begin
            // A tick in the placement cycle is ignored: the slot is still
            // idle here, so the fresh fuse starts at its full length.
            if (accept_d && free_idx_d == SLOT_W'(i)) begin
              state_q[i] <= S_ARMED;
              cnt_q[i]   <= CNT_W'(FUSE_SEC);
              row_q[i]   <= place_row;
              col_q[i]   <= place_col;
            end
          end
          S_ARMED: begin
            // Chain and terminal tick share one branch, so a coincidence
            // still yields a single explode pulse.
            if (chain_det[i] || (one_sec && cnt_q[i] == CNT_W'(1))) begin
              state_q[i]   <= S_BLAST;
              cnt_q[i]     <= CNT_W'(BLAST_SEC);
              explode_q[i] <= 1'b1;
            end else if (one_sec) begin
              cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
          end
          S_BLAST: begin
            if (one_sec && cnt_q[i] == CNT_W'(1)) begin
              state_q[i] <= S_IDLE;
              cnt_q[i]   <= '0;
              row_q[i]   <= '0;
              col_q[i]   <= '0;
            end else if (one_sec) begin
              cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
          end
          default: begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
            row_q[i]   <= '0;
            col_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Output decode from registered state only.
  always_comb begin
    armed    = '0;
    blasting = '0;
    slot_row = '0;
    slot_col = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      armed[i]                         = (state_q[i] == S_ARMED);
      blasting[i]                      = (state_q[i] == S_BLAST);
      slot_row[i*COORD_W +: COORD_W]   = row_q[i];
      slot_col[i*COORD_W +: COORD_W]   = col_q[i];
    end
  end

  assign place_ack     = place_ack_q;
  assign place_nack    = place_nack_q;
  assign place_slot    = place_slot_q;
  assign explode_pulse = explode_q;

endmodule
